// File: rtl/rv32_decode.sv
// rv32_decode: RV32I decode stage; drives reg32Blk read ports on accept and registers decoded
// fields for execute. Optional RAW scoreboard is enabled by defining DECODE_SCOREBOARD_EN.
module rv32_decode #(
  parameter int unsigned D_WIDTH = 32,
  parameter int unsigned A_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [D_WIDTH-1:0] instr,
  input  logic [D_WIDTH-1:0] instrPc,
  input  logic               instrValid,
  output logic               instrReady,
  output logic [A_WIDTH-1:0] rs1,
  output logic [A_WIDTH-1:0] rs2,
  output logic               regLd,
  output logic               decValid,
  input  logic               decReady,
  output logic [D_WIDTH-1:0] decPc,
  output logic [3:0]         decClass,
  output logic [A_WIDTH-1:0] decRd,
  output logic               decRdWe,
  output logic [2:0]         decFunct3,
  output logic               decFunct7b5,
  output logic [D_WIDTH-1:0] decImm,
  output logic               decIllegal,
  input  logic               wbValid,
  input  logic [A_WIDTH-1:0] wbRd
);

  typedef enum logic [3:0] {
    ClsLui    = 4'd0,
    ClsAuipc  = 4'd1,
    ClsJal    = 4'd2,
    ClsJalr   = 4'd3,
    ClsBranch = 4'd4,
    ClsLoad   = 4'd5,
    ClsStore  = 4'd6,
    ClsOpImm  = 4'd7,
    ClsOp     = 4'd8,
    ClsFence  = 4'd9,
    ClsSystem = 4'd10
  } cls_e;

  logic [A_WIDTH-1:0] rd;
  logic [D_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  cls_e               cls_c;
  logic               illegal_c, we_c, use_rs1_c, use_rs2_c;
  logic [D_WIDTH-1:0] imm_c;
  logic               hazard, accept;

  logic               dec_valid_q, dec_we_q, dec_f7b5_q, dec_illegal_q;
  logic [D_WIDTH-1:0] dec_pc_q, dec_imm_q;
  cls_e               dec_class_q;
  logic [A_WIDTH-1:0] dec_rd_q;
  logic [2:0]         dec_f3_q;

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];

  assign imm_i = {{(D_WIDTH-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(D_WIDTH-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(D_WIDTH-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{(D_WIDTH-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    cls_c     = ClsSystem;
    illegal_c = 1'b1;
    we_c      = 1'b0;
    use_rs1_c = 1'b0;
    use_rs2_c = 1'b0;
    imm_c     = '0;
    if (instr[1:0] == 2'b11) begin
      illegal_c = 1'b0;
      case (instr[6:2])
        5'b01101: begin cls_c = ClsLui;    we_c = 1'b1; imm_c = imm_u; end
        5'b00101: begin cls_c = ClsAuipc;  we_c = 1'b1; imm_c = imm_u; end
        5'b11011: begin cls_c = ClsJal;    we_c = 1'b1; imm_c = imm_j; end
        5'b11001: begin cls_c = ClsJalr;   we_c = 1'b1; use_rs1_c = 1'b1; imm_c = imm_i; end
        5'b11000: begin
          cls_c = ClsBranch; use_rs1_c = 1'b1; use_rs2_c = 1'b1; imm_c = imm_b;
        end
        5'b00000: begin cls_c = ClsLoad;   we_c = 1'b1; use_rs1_c = 1'b1; imm_c = imm_i; end
        5'b01000: begin
          cls_c = ClsStore; use_rs1_c = 1'b1; use_rs2_c = 1'b1; imm_c = imm_s;
        end
        5'b00100: begin cls_c = ClsOpImm;  we_c = 1'b1; use_rs1_c = 1'b1; imm_c = imm_i; end
        5'b01100: begin cls_c = ClsOp;     we_c = 1'b1; use_rs1_c = 1'b1; use_rs2_c = 1'b1; end
        5'b00011: cls_c = ClsFence;
        5'b11100: cls_c = ClsSystem;
        default:  illegal_c = 1'b1;
      endcase
    end
    // x0 is hardwired, so it never counts as a write target.
    if (rd == '0) we_c = 1'b0;
  end

`ifdef DECODE_SCOREBOARD_EN
  logic [31:0] pending_q, pending_d;

  assign hazard = (use_rs1_c && pending_q[rs1]) || (use_rs2_c && pending_q[rs2]) ||
                  (we_c && pending_q[rd]);

  // Set after clear so a same-cycle retire and reissue of one register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wbValid) pending_d[wbRd] = 1'b0;
    if (accept && we_c) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end
`else
  logic unused_sb;
  assign unused_sb = ^{wbValid, wbRd, use_rs1_c, use_rs2_c};
  assign hazard    = 1'b0;
`endif

  assign instrReady = !rst && !(dec_valid_q && !decReady) && !hazard;
  assign accept     = instrValid && instrReady;
  assign regLd      = accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_q   <= 1'b0;
      dec_pc_q      <= '0;
      dec_class_q   <= ClsLui;
      dec_rd_q      <= '0;
      dec_we_q      <= 1'b0;
      dec_f3_q      <= '0;
      dec_f7b5_q    <= 1'b0;
      dec_imm_q     <= '0;
      dec_illegal_q <= 1'b0;
    end else if (accept) begin
      dec_valid_q   <= 1'b1;
      dec_pc_q      <= instrPc;
      dec_class_q   <= cls_c;
      dec_rd_q      <= rd;
      dec_we_q      <= we_c;
      dec_f3_q      <= instr[14:12];
      dec_f7b5_q    <= instr[30];
      dec_imm_q     <= imm_c;
      dec_illegal_q <= illegal_c;
    end else if (decReady) begin
      dec_valid_q   <= 1'b0;
    end
  end

  assign decValid    = dec_valid_q;
  assign decPc       = dec_pc_q;
  assign decClass    = dec_class_q;
  assign decRd       = dec_rd_q;
  assign decRdWe     = dec_we_q;
  assign decFunct3   = dec_f3_q;
  assign decFunct7b5 = dec_f7b5_q;
  assign decImm      = dec_imm_q;
  assign decIllegal  = dec_illegal_q;

endmodule

// File: tb/tb_rv32_decode.sv
// Bench for rv32_decode: opcode-table decode model checked every cycle plus literal pins.
// Follows DECODE_SCOREBOARD_EN the same way the design does.
module tb_rv32_decode;

  logic        clk = 1'b0;
  logic        rst, instrValid, decReady, wbValid;
  logic [31:0] instr, instrPc;
  logic [4:0]  wbRd;
  logic        instrReady, regLd, decValid, decRdWe, decFunct7b5, decIllegal;
  logic [4:0]  rs1, rs2, decRd;
  logic [31:0] decPc, decImm;
  logic [3:0]  decClass;
  logic [2:0]  decFunct3;

  always #5 clk = ~clk;

  rv32_decode dut (
    .clk(clk), .rst(rst), .instr(instr), .instrPc(instrPc), .instrValid(instrValid),
    .instrReady(instrReady), .rs1(rs1), .rs2(rs2), .regLd(regLd), .decValid(decValid),
    .decReady(decReady), .decPc(decPc), .decClass(decClass), .decRd(decRd),
    .decRdWe(decRdWe), .decFunct3(decFunct3), .decFunct7b5(decFunct7b5), .decImm(decImm),
    .decIllegal(decIllegal), .wbValid(wbValid), .wbRd(wbRd)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: class is the position of the opcode in this list; everything else is looked up.
  typedef struct {
    logic [3:0]  cls;
    logic        we, ill, u1, u2;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t mdec(input logic [31:0] ins);
    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
                             7'h0F, 7'h73};
    bit         rd_writers [11] = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 0, 0};
    bit         rs1_users [11]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0};
    bit         rs2_users [11]  = '{0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0};
    string      kind = "UUJIBISINNN";
    dec_t d;
    int   s, hi, c;
    s = $signed(ins);
    c = -1;
    for (int i = 0; i < 11; i++) if (ins[6:0] == ops[i]) c = i;
    d.cls = 4'd10; d.ill = 1'b1; d.we = 1'b0; d.u1 = 1'b0; d.u2 = 1'b0; d.imm = 32'd0;
    if (c >= 0) begin
      d.cls = 4'(c);
      d.ill = 1'b0;
      d.we  = rd_writers[c] && (ins[11:7] != 5'd0);
      d.u1  = rs1_users[c];
      d.u2  = rs2_users[c];
      hi    = s >>> 31;
      case (kind[c])
        "I": d.imm = s >>> 20;
        "S": begin hi = s >>> 25; d.imm = hi * 32 + int'(ins[11:7]); end
        "B": d.imm = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                     + int'(ins[11:8]) * 2;
        "U": d.imm = ins & 32'hFFFF_F000;
        "J": d.imm = hi * (1 << 20) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                     + int'(ins[30:21]) * 2;
        default: d.imm = 32'd0;
      endcase
    end
    return d;
  endfunction

  logic        m_valid = 0, m_we = 0, m_f7 = 0, m_ill = 0;
  logic [31:0] m_pc = 0, m_imm = 0;
  logic [3:0]  m_cls = 0;
  logic [4:0]  m_rd = 0;
  logic [2:0]  m_f3 = 0;
  bit          m_pend [32];

  function automatic logic m_ready();
    dec_t d;
    logic hz;
    d  = mdec(instr);
    hz = 1'b0;
`ifdef DECODE_SCOREBOARD_EN
    hz = (d.u1 && m_pend[instr[19:15]]) || (d.u2 && m_pend[instr[24:20]]) ||
         (d.we && m_pend[instr[11:7]]);
`endif
    return !rst && !(m_valid && !decReady) && !hz;
  endfunction

  always @(posedge clk) begin
    dec_t d;
    logic acc;
    acc = instrValid && m_ready();
    d   = mdec(instr);
    if (rst) begin
      m_valid = 0; m_pc = 0; m_cls = 0; m_rd = 0; m_we = 0; m_f3 = 0; m_f7 = 0;
      m_imm = 0; m_ill = 0;
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    end else begin
      if (wbValid) m_pend[wbRd] = 1'b0;
      if (acc) begin
        m_valid = 1; m_pc = instrPc; m_cls = d.cls; m_rd = instr[11:7]; m_we = d.we;
        m_f3 = instr[14:12]; m_f7 = instr[30]; m_imm = d.imm; m_ill = d.ill;
        if (d.we) m_pend[instr[11:7]] = 1'b1;
      end else if (decReady) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("instrReady", instrReady, m_ready());
      chk("regLd", regLd, instrValid && m_ready());
      chk("rs1", rs1, instr[19:15]);
      chk("rs2", rs2, instr[24:20]);
      chk("decValid", decValid, m_valid);
      chk("decPc", decPc, m_pc);
      chk("decClass", decClass, m_cls);
      chk("decRd", decRd, m_rd);
      chk("decRdWe", decRdWe, m_we);
      chk("decFunct3", decFunct3, m_f3);
      chk("decFunct7b5", decFunct7b5, m_f7);
      chk("decImm", decImm, m_imm);
      chk("decIllegal", decIllegal, m_ill);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    instr = ins; instrPc = pc; instrValid = 1'b1; n = 0;
    #1;
    while (!m_ready() && n < 8) begin
      step();
      n++;
    end
    total++;
    if (n >= 8) begin
      bad++;
      $display("FAIL send_timeout instr=%h waited=%0d want<8", ins, n);
      instrValid = 1'b0;
    end
    step();
  endtask

  logic [31:0] tbl [10] = '{32'hFE208EE3, 32'h008004EF, 32'h00008067, 32'hFF812183,
                            32'h80000217, 32'h0FF0000F, 32'h00000073, 32'h00000001,
                            32'h800000EF, 32'h4020D093};

  initial begin
    rst = 1; instrValid = 1; instr = 32'hFFF00293; instrPc = 32'h100; decReady = 1;
    wbValid = 0; wbRd = 0;
    step();
    chk_on = 1'b1;
    step(); step();
    @(negedge clk);
    chk("rst_ready", instrReady, 0); chk("rst_regLd", regLd, 0);
    chk("rst_decValid", decValid, 0); chk("rst_decPc", decPc, 0);
    step(); rst = 0; instrValid = 0;
    @(negedge clk); chk("post_rst_ready", instrReady, 1);

    // ADDI x5,x0,-1
    step(); instrValid = 1; instr = 32'hFFF00293; instrPc = 32'h100;
    @(negedge clk); chk("addi_regLd", regLd, 1); chk("addi_rs1", rs1, 0);
    step(); instr = 32'h00528333; instrPc = 32'h104;
    @(negedge clk);
    chk("addi_valid", decValid, 1); chk("addi_class", decClass, 7);
    chk("addi_rd", decRd, 5); chk("addi_we", decRdWe, 1);
    chk("addi_imm", decImm, 32'hFFFF_FFFF); chk("addi_pc", decPc, 32'h100);
`ifdef DECODE_SCOREBOARD_EN
    chk("raw_stall0", instrReady, 0);
    step(); @(negedge clk); chk("raw_stall1", instrReady, 0);
    step(); wbValid = 1; wbRd = 5;
    @(negedge clk); chk("raw_stall_wb", instrReady, 0);
    step(); wbValid = 0;
    @(negedge clk); chk("raw_release", instrReady, 1); chk("raw_regLd", regLd, 1);
    step();
`else
    chk("raw_b2b", instrReady, 1);
    step();
`endif
    // SW x2,8(x1)
    instr = 32'h0020A423; instrPc = 32'h108;
    @(negedge clk);
    chk("add_class", decClass, 8); chk("add_rd", decRd, 6); chk("add_imm", decImm, 0);
    chk("sw_rs1", rs1, 1); chk("sw_rs2", rs2, 2);
    step(); wbValid = 1; wbRd = 6; decReady = 0; instr = 32'h123453B7; instrPc = 32'h10C;
    @(negedge clk);
    chk("sw_class", decClass, 6); chk("sw_imm", decImm, 8); chk("sw_we", decRdWe, 0);
    chk("bp_regLd0", regLd, 0); chk("bp_ready0", instrReady, 0);
    step(); wbValid = 0;
    @(negedge clk); chk("bp_regLd1", regLd, 0); chk("bp_class1", decClass, 6);
    step();
    @(negedge clk); chk("bp_regLd2", regLd, 0); chk("bp_imm2", decImm, 8);
    step(); decReady = 1;
    @(negedge clk); chk("bp_rel_ready", instrReady, 1); chk("bp_rel_regLd", regLd, 1);
    step(); instr = 32'h00000F80; instrPc = 32'h110;
    @(negedge clk);
    chk("lui_class", decClass, 0); chk("lui_imm", decImm, 32'h1234_5000); chk("lui_rd", decRd, 7);
    step(); instr = 32'h000F8093; instrPc = 32'h114;
    @(negedge clk);
    chk("ill_flag", decIllegal, 1); chk("ill_class", decClass, 10);
    chk("ill_we", decRdWe, 0); chk("ill_imm", decImm, 0); chk("ill_no_pend", instrReady, 1);
    step(); instrValid = 0;
    @(negedge clk); chk("ill_next_ok", decIllegal, 0); chk("ill_next_class", decClass, 7);

    for (int r = 1; r < 32; r++) begin
      wbValid = 1; wbRd = 5'(r);
      step();
    end
    wbValid = 0;
    for (int i = 0; i < 10; i++) send(tbl[i], 32'h200 + 32'(i) * 4);
    instrValid = 0;
    repeat (3) step();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
